// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: funct3 codes, FSM state encoding
// and access-size byte masks.
package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_D  = 3'b011;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;
    localparam logic [2:0] F3_WU = 3'b110;

    localparam logic [7:0] MASK_B = 8'h01;
    localparam logic [7:0] MASK_H = 8'h03;
    localparam logic [7:0] MASK_W = 8'h0F;
    localparam logic [7:0] MASK_D = 8'hFF;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_RESP = 2'd2
    } lsu_state_t;

    // funct3[1:0] encodes log2 of the access size in bytes
    function automatic logic [7:0] size_mask(input logic [1:0] size);
        case (size)
            2'd0:    size_mask = MASK_B;
            2'd1:    size_mask = MASK_H;
            2'd2:    size_mask = MASK_W;
            default: size_mask = MASK_D;
        endcase
    endfunction

endpackage

// File: rtl/lsu_if.sv
// Data-memory request/acknowledge bus between the load/store unit (master)
// and the memory (slave).
interface lsu_if #(
    parameter int XLEN   = 32,
    parameter int ADDR_W = 32
) ();
    logic                mem_req;
    logic                mem_we;
    logic [ADDR_W-1:0]   mem_addr;
    logic [XLEN/8-1:0]   mem_be;
    logic [XLEN-1:0]     mem_wdata;
    logic [XLEN-1:0]     mem_rdata;
    logic                mem_ack;

    modport master (
        output mem_req, mem_we, mem_addr, mem_be, mem_wdata,
        input  mem_rdata, mem_ack
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_be, mem_wdata,
        output mem_rdata, mem_ack
    );
endinterface

// File: rtl/lsu_align.sv
// Combinational lane logic: legality, alignment, byte enables, store-data
// replication and load formatting. MISALIGN_TRAP_EN makes misalignment visible.
module lsu_align
    import lsu_pkg::*;
#(
    parameter  int XLEN  = 32,
    localparam int LANES = XLEN / 8,
    localparam int OFF_W = $clog2(LANES)
) (
    input  logic             is_store,
    input  logic [2:0]       funct3,
    input  logic [OFF_W-1:0] offset,
    input  logic [XLEN-1:0]  wdata,
    input  logic [XLEN-1:0]  mem_rdata,
    output logic [LANES-1:0] be,
    output logic [XLEN-1:0]  wdata_lane,
    output logic [XLEN-1:0]  load_data,
    output logic             legal,
    output logic             aligned
);
    logic [1:0]       size;
    logic [OFF_W-1:0] amask;
    logic [OFF_W-1:0] off_al;
    logic [XLEN-1:0]  shifted;

    assign size = funct3[1:0];

    always_comb begin
        case (size)
            2'd0:    amask = '0;
            2'd1:    amask = OFF_W'(1);
            2'd2:    amask = OFF_W'(3);
            default: amask = OFF_W'(7);
        endcase
    end

    // Offset rounded down to the access size; identical to offset when aligned
    assign off_al = offset & ~amask;

`ifdef MISALIGN_TRAP_EN
    assign aligned = ((offset & amask) == '0);
`else
    assign aligned = 1'b1;
`endif

    always_comb begin
        case (funct3)
            F3_B, F3_H, F3_W: legal = 1'b1;
            F3_BU, F3_HU:     legal = !is_store;
            F3_D:             legal = (XLEN == 64);
            F3_WU:            legal = (XLEN == 64) && !is_store;
            default:          legal = 1'b0;
        endcase
    end

    assign be = LANES'(size_mask(size)) << off_al;

    always_comb begin
        case (size)
            2'd0:    wdata_lane = {LANES{wdata[7:0]}};
            2'd1:    wdata_lane = {(LANES/2){wdata[15:0]}};
            2'd2:    wdata_lane = {(LANES/4){wdata[31:0]}};
            default: wdata_lane = wdata;
        endcase
    end

    assign shifted = mem_rdata >> {off_al, 3'b000};

    always_comb begin
        case (size)
            2'd0:    load_data = funct3[2] ? XLEN'(shifted[7:0])  : XLEN'($signed(shifted[7:0]));
            2'd1:    load_data = funct3[2] ? XLEN'(shifted[15:0]) : XLEN'($signed(shifted[15:0]));
            2'd2:    load_data = funct3[2] ? XLEN'(shifted[31:0]) : XLEN'($signed(shifted[31:0]));
            default: load_data = shifted;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Multi-cycle load/store engine: IDLE -> REQ -> RESP handshake with timeout.
// Misaligned accesses trap when MISALIGN_TRAP_EN is defined (see lsu_align).
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int ADDR_W  = 32,
    parameter int TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              is_store,
    input  logic [2:0]        funct3,
    input  logic [ADDR_W-1:0] addr,
    input  logic [XLEN-1:0]   wdata,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [XLEN-1:0]   rdata,
    lsu_if.master             mem
);
    localparam int LANES = XLEN / 8;
    localparam int OFF_W = $clog2(LANES);
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    lsu_state_t        state_reg;
    logic              store_reg;
    logic [2:0]        f3_reg;
    logic [OFF_W-1:0]  off_reg;
    logic [CNT_W-1:0]  cnt_reg;
    logic              mem_req_reg, mem_we_reg, done_reg, err_reg;
    logic [ADDR_W-1:0] mem_addr_reg;
    logic [LANES-1:0]  mem_be_reg;
    logic [XLEN-1:0]   mem_wdata_reg, rdata_reg;

    logic              idle;
    logic              al_store, al_legal, al_aligned;
    logic [2:0]        al_f3;
    logic [OFF_W-1:0]  al_off;
    logic [LANES-1:0]  al_be;
    logic [XLEN-1:0]   al_wdata, al_load;

    assign idle = (state_reg == S_IDLE);

    // In IDLE the aligner looks at the incoming request; afterwards at the latched one
    assign al_store = idle ? is_store : store_reg;
    assign al_f3    = idle ? funct3 : f3_reg;
    assign al_off   = idle ? addr[OFF_W-1:0] : off_reg;

    lsu_align #(.XLEN(XLEN)) u_align (
        .is_store   (al_store),
        .funct3     (al_f3),
        .offset     (al_off),
        .wdata      (wdata),
        .mem_rdata  (mem.mem_rdata),
        .be         (al_be),
        .wdata_lane (al_wdata),
        .load_data  (al_load),
        .legal      (al_legal),
        .aligned    (al_aligned)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg     <= S_IDLE;
            store_reg     <= 1'b0;
            f3_reg        <= '0;
            off_reg       <= '0;
            cnt_reg       <= '0;
            mem_req_reg   <= 1'b0;
            mem_we_reg    <= 1'b0;
            mem_addr_reg  <= '0;
            mem_be_reg    <= '0;
            mem_wdata_reg <= '0;
            rdata_reg     <= '0;
            done_reg      <= 1'b0;
            err_reg       <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            err_reg  <= 1'b0;
            case (state_reg)
                S_IDLE: begin
                    if (start) begin
                        store_reg <= is_store;
                        f3_reg    <= funct3;
                        off_reg   <= addr[OFF_W-1:0];
                        if (!al_legal || !al_aligned) begin
                            state_reg <= S_RESP;
                            done_reg  <= 1'b1;
                            err_reg   <= 1'b1;
                            rdata_reg <= '0;
                        end else begin
                            state_reg     <= S_REQ;
                            mem_req_reg   <= 1'b1;
                            mem_we_reg    <= is_store;
                            mem_addr_reg  <= {addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
                            mem_be_reg    <= al_be;
                            mem_wdata_reg <= al_wdata;
                        end
                    end
                end
                S_REQ: begin
                    if (mem.mem_ack) begin
                        state_reg   <= S_RESP;
                        mem_req_reg <= 1'b0;
                        cnt_reg     <= '0;
                        done_reg    <= 1'b1;
                        if (!store_reg) rdata_reg <= al_load;
                    end else if (cnt_reg == CNT_W'(TIMEOUT - 1)) begin
                        state_reg   <= S_RESP;
                        mem_req_reg <= 1'b0;
                        cnt_reg     <= '0;
                        done_reg    <= 1'b1;
                        err_reg     <= 1'b1;
                        rdata_reg   <= '0;
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end
                S_RESP:  state_reg <= S_IDLE;
                default: state_reg <= S_IDLE;
            endcase
        end
    end

    assign busy          = !idle;
    assign done          = done_reg;
    assign err           = err_reg;
    assign rdata         = rdata_reg;
    assign mem.mem_req   = mem_req_reg;
    assign mem.mem_we    = mem_we_reg;
    assign mem.mem_addr  = mem_addr_reg;
    assign mem.mem_be    = mem_be_reg;
    assign mem.mem_wdata = mem_wdata_reg;

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: spec-level model of each transaction's
// timeline and data, checked every cycle, plus literal expectations.
module tb_load_store_unit;
    localparam int XLEN    = 32;
    localparam int ADDR_W  = 32;
    localparam int TIMEOUT = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0, is_store = 1'b0;
    logic [2:0]  funct3 = '0;
    logic [31:0] addr = '0, wdata = '0;
    logic        busy, done, err;
    logic [31:0] rdata;

    always #5 clk = ~clk;

    lsu_if #(.XLEN(XLEN), .ADDR_W(ADDR_W)) mem_bus ();

    load_store_unit #(.XLEN(XLEN), .ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .is_store (is_store),
        .funct3   (funct3),
        .addr     (addr),
        .wdata    (wdata),
        .busy     (busy),
        .done     (done),
        .err      (err),
        .rdata    (rdata),
        .mem      (mem_bus)
    );

    int checks = 0;
    int errors = 0;
    int txn_no = 0;

    bit          cmp_en = 1'b0;
    logic        exp_busy = 0, exp_done = 0, exp_err = 0, exp_req = 0, exp_we = 0;
    logic [31:0] exp_rdata = '0, exp_addr = '0, exp_wdata = '0;
    logic [3:0]  exp_be = '0;
    logic        last_we;
    logic [3:0]  last_be;
    logic [31:0] last_addr, last_wdata;
    int          last_req_cycles;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %h, want %h", name, act, expv);
        end
    endtask

    // Spec-level model of one access, written with plain arithmetic
    function automatic void model(input bit st, input logic [2:0] f3, input logic [31:0] a,
                                  input logic [31:0] wd, input logic [31:0] rd,
                                  output bit fault, output logic [3:0] be,
                                  output logic [31:0] ma, output logic [31:0] wrep,
                                  output logic [31:0] ld);
        int sz, off, eoff;
        bit legal;
        logic [31:0] raw, mask;
        sz  = 1 << f3[1:0];
        off = int'(a % 4);
        legal = st ? (f3 <= 3'd2)
                   : (f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd2 || f3 == 3'd4 || f3 == 3'd5);
        fault = !legal;
`ifdef MISALIGN_TRAP_EN
        if (off % sz != 0) fault = 1'b1;
`endif
        eoff = off - (off % sz);
        be   = 4'(((1 << sz) - 1) << eoff);
        ma   = a & ~32'h3;
        if (sz == 1)      wrep = {24'h0, wd[7:0]} * 32'h0101_0101;
        else if (sz == 2) wrep = {16'h0, wd[15:0]} * 32'h0001_0001;
        else              wrep = wd;
        raw  = rd >> (8 * eoff);
        mask = (sz >= 4) ? 32'hFFFF_FFFF : ((32'h1 << (8 * sz)) - 1);
        ld   = raw & mask;
        if (!f3[2] && sz < 4 && raw[8*sz-1]) ld = ld | ~mask;
    endfunction

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("busy", busy, exp_busy);
            chk("done", done, exp_done);
            chk("err", err, exp_err);
            chk("rdata", rdata, exp_rdata);
            chk("mem_req", mem_bus.mem_req, exp_req);
            if (exp_req) begin
                chk("mem_addr", mem_bus.mem_addr, exp_addr);
                chk("mem_be", mem_bus.mem_be, exp_be);
                chk("mem_we", mem_bus.mem_we, exp_we);
                if (exp_we) chk("mem_wdata", mem_bus.mem_wdata, exp_wdata);
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic noise_inputs(input bit noise);
        start = noise ? 1'($urandom_range(0, 1)) : 1'b0;
        if (noise) begin
            is_store = 1'($urandom_range(0, 1));
            funct3   = 3'($urandom_range(0, 7));
            addr     = $urandom;
            wdata    = $urandom;
        end
    endtask

    // k = cycle index of ack (>=1); k = 0 means never ack (timeout)
    task automatic run_txn(input bit st, input logic [2:0] f3, input logic [31:0] a,
                           input logic [31:0] wd, input logic [31:0] rd,
                           input int k, input bit noise);
        bit fault;
        logic [3:0]  be;
        logic [31:0] ma, wrep, ld;
        int lim;
        model(st, f3, a, wd, rd, fault, be, ma, wrep, ld);
        txn_no++;
        $display("txn %0d %s f3=%0d addr=%h wdata=%h rdata_in=%h k=%0d fault=%0d",
                 txn_no, st ? "ST" : "LD", f3, a, wd, rd, k, fault);
        last_req_cycles = 0;
        start = 1'b1; is_store = st; funct3 = f3; addr = a; wdata = wd;
        exp_busy = 0; exp_req = 0; exp_done = 0; exp_err = 0;
        cyc();
        noise_inputs(noise);
        if (fault) begin
            exp_busy = 1; exp_done = 1; exp_err = 1; exp_rdata = '0;
            cyc();
        end else begin
            exp_busy = 1; exp_req = 1; exp_addr = ma; exp_be = be; exp_we = st; exp_wdata = wrep;
            last_we = mem_bus.mem_we; last_be = mem_bus.mem_be;
            last_addr = mem_bus.mem_addr; last_wdata = mem_bus.mem_wdata;
            lim = (k == 0) ? TIMEOUT : k;
            for (int c = 1; c <= lim; c++) begin
                if (mem_bus.mem_req) last_req_cycles++;
                noise_inputs(noise);
                mem_bus.mem_ack   = (c == k);
                mem_bus.mem_rdata = (c == k) ? rd : $urandom;
                cyc();
            end
            mem_bus.mem_ack = 1'b0;
            if (mem_bus.mem_req) last_req_cycles++;
            noise_inputs(noise);
            exp_req = 0; exp_done = 1; exp_err = (k == 0);
            if (k == 0) exp_rdata = '0;
            else if (!st) exp_rdata = ld;
            cyc();
        end
        start = 1'b0;
        exp_busy = 0; exp_done = 0; exp_err = 0;
    endtask

    initial begin
        mem_bus.mem_ack   = 1'b0;
        mem_bus.mem_rdata = '0;
        repeat (2) cyc();
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        chk("rst_rdata", rdata, 0);
        chk("rst_mem_req", mem_bus.mem_req, 0);
        chk("rst_mem_be", mem_bus.mem_be, 0);
        chk("rst_mem_addr", mem_bus.mem_addr, 0);
        rst = 1'b0;
        cmp_en = 1'b1;
        cyc();

        run_txn(0, 3'b000, 32'h103, 32'h0, 32'h80FF_FF7F, 2, 0);
        chk("lb_rdata", rdata, 32'hFFFF_FF80);
        chk("lb_be", last_be, 4'b1000);
        chk("lb_addr", last_addr, 32'h100);

        run_txn(0, 3'b101, 32'h102, 32'h0, 32'h8001_0000, 1, 0);
        chk("lhu_rdata", rdata, 32'h0000_8001);
        chk("lhu_be", last_be, 4'b1100);

        run_txn(1, 3'b000, 32'h201, 32'h1234_56AB, 32'hFFFF_FFFF, 1, 1);
        chk("sb_we", last_we, 1);
        chk("sb_be", last_be, 4'b0010);
        chk("sb_wdata", last_wdata, 32'hABAB_ABAB);
        chk("sb_rdata_kept", rdata, 32'h0000_8001);

        run_txn(0, 3'b010, 32'h400, 32'h0, 32'h0, 0, 1);
        chk("to_rdata", rdata, 0);
        chk("to_req_cycles", last_req_cycles, TIMEOUT);

        run_txn(0, 3'b100, 32'h0, 32'h0, 32'h0000_00FE, 1, 0);
        chk("lbu_after_to", rdata, 32'h0000_00FE);

        run_txn(0, 3'b111, 32'h10, 32'h0, 32'h0, 1, 0);
        chk("f3_111_rdata", rdata, 0);
        chk("f3_111_no_req", last_req_cycles, 0);

        run_txn(0, 3'b010, 32'h102, 32'h0, 32'hDEAD_BEEF, 2, 0);
`ifdef MISALIGN_TRAP_EN
        chk("lw_mis_rdata", rdata, 0);
        chk("lw_mis_no_req", last_req_cycles, 0);
`else
        chk("lw_mis_rdata", rdata, 32'hDEAD_BEEF);
        chk("lw_mis_be", last_be, 4'b1111);
        chk("lw_mis_addr", last_addr, 32'h100);
`endif

        // Reset in the middle of a request
        $display("txn %0d LD reset during REQ", txn_no + 1);
        txn_no++;
        start = 1'b1; is_store = 1'b0; funct3 = 3'b010; addr = 32'h300;
        cyc();
        start = 1'b0;
        exp_busy = 1; exp_req = 1; exp_addr = 32'h300; exp_be = 4'hF; exp_we = 0;
        cyc();
        #2;
        rst = 1'b1;
        exp_busy = 0; exp_req = 0; exp_done = 0; exp_err = 0; exp_rdata = '0;
        #1;
        chk("rst_async_req", mem_bus.mem_req, 0);
        chk("rst_async_busy", busy, 0);
        cyc();
        rst = 1'b0;
        repeat (3) cyc();

        for (int i = 0; i < 60; i++) begin
            run_txn(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), $urandom, $urandom, $urandom,
                    ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, 4), 1);
        end
        cyc();
        cmp_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
